// File: rtl/dmem_wait_ctrl_if.sv
// Data-memory request/response bundle between the CPU data port and
// dmem_wait_ctrl. The master issues requests; the slave (memory) answers.
interface dmem_wait_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, busy, addr_err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, busy, addr_err
    );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// Data memory with request/ready handshake and programmable wait states.
// Byte/half/word access, little-endian lane steering, sign/zero extension.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are suppressed and flagged on addr_err; otherwise the
// low address bits are forced to alignment and addr_err is tied low.
module dmem_wait_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_wait_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done;

    logic [31:0]         mem [0:DEPTH-1];

    // Upper address bits only alias; kept visible so the intent is explicit.
    logic                addr_hi_unused;
    assign addr_hi_unused = ^bus.addr[31:ADDR_W+2];

    // Effective lane address and misalignment.
    logic [1:0]          lo;
    logic                mis;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign lo  = addr_q[1:0];
    assign mis = ((size_q == 2'd1) && addr_q[0]) ||
                 (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign lo  = size_q[1]         ? 2'b00 :
                 (size_q == 2'd1)  ? {addr_q[1], 1'b0} : addr_q[1:0];
    assign mis = 1'b0;
`endif

    logic [ADDR_W-1:0]   widx;
    logic [31:0]         rword;
    logic [7:0]          lb;
    logic [15:0]         lh;
    logic [31:0]         ld_val;
    logic [3:0]          be;
    logic [31:0]         wlane;
    logic                mem_we;

    assign widx  = addr_q[ADDR_W+1:2];
    assign rword = mem[widx];
    assign lb    = rword[{lo, 3'b000} +: 8];
    assign lh    = rword[{lo[1], 4'b0000} +: 16];

    // Lane steering: byte enables, replicated store data, extended load data.
    always_comb begin
        be     = 4'b1111;
        wlane  = wdata_q;
        ld_val = rword;
        case (size_q)
            2'd0: begin
                be     = 4'b0001 << lo;
                wlane  = {4{wdata_q[7:0]}};
                ld_val = {{24{sext_q & lb[7]}}, lb};
            end
            2'd1: begin
                be     = lo[1] ? 4'b1100 : 4'b0011;
                wlane  = {2{wdata_q[15:0]}};
                ld_val = {{16{sext_q & lh[15]}}, lh};
            end
            default: ;
        endcase
    end

    assign mem_we = done && we_q && !mis;

    // RAM write with byte enables; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // Next-state: accept in IDLE, count wait states, complete in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sext_d  = bus.sign_ext;
                    addr_d  = bus.addr[ADDR_W+1:0];
                    wdata_d = bus.wdata;
                    cnt_d   = 8'(WAIT_STATES);
                    busy_d  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    done    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!we_q && !mis) rdata_d = ld_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_q;

    // Misalignment flag pulses together with ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= done && mis;
    end

    assign bus.addr_err = err_q;
`else
    assign bus.addr_err = 1'b0;
`endif

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Self-checking bench for dmem_wait_ctrl: one instance with no wait states
// and one with three, sharing clock and reset. Expected load results are
// queued when a request is issued and popped when its ready pulse arrives.
module tb_dmem_wait_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_q [$];

    dmem_wait_ctrl_if bus0();
    dmem_wait_ctrl_if bus3();

    dmem_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    dmem_wait_ctrl #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drv(input bit sel, input bit req, input bit we, input logic [1:0] size,
                       input bit sext, input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus3.req = req; bus3.we = we; bus3.size = size;
            bus3.sign_ext = sext; bus3.addr = addr; bus3.wdata = wdata;
        end else begin
            bus0.req = req; bus0.we = we; bus0.size = size;
            bus0.sign_ext = sext; bus0.addr = addr; bus0.wdata = wdata;
        end
    endtask

    function automatic logic s_ready(input bit sel);
        return sel ? bus3.ready : bus0.ready;
    endfunction
    function automatic logic s_busy(input bit sel);
        return sel ? bus3.busy : bus0.busy;
    endfunction
    function automatic logic [31:0] s_rdata(input bit sel);
        return sel ? bus3.rdata : bus0.rdata;
    endfunction
    function automatic logic s_err(input bit sel);
        return sel ? bus3.addr_err : bus0.addr_err;
    endfunction

    // Issue one access, wait (bounded) for ready; report latency in edges
    // after the accept edge and the number of cycles busy was seen high.
    task automatic do_acc(input bit sel, input bit we, input logic [1:0] size, input bit sext,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat, output int bcyc);
        @(negedge clk);
        drv(sel, 1'b1, we, size, sext, addr, wdata);
        @(posedge clk);
        @(negedge clk);
        drv(sel, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        bcyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_busy(sel)) bcyc++;
            if (s_ready(sel)) break;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rd  = s_rdata(sel);
        err = s_err(sel);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        n_tests++; if (bus0.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus0.rdata); end
        n_tests++; if (bus0.ready !== 1'b0 || bus3.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b%b exp=00", bus0.ready, bus3.ready); end
        n_tests++; if (bus0.busy !== 1'b0 || bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b%b exp=00", bus0.busy, bus3.busy); end
        n_tests++; if (bus0.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got=%b exp=0", bus0.addr_err); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word;
        logic [31:0] rd, e; logic err; int lat, bc;
        exp_q.push_back(32'h0);                 // store leaves reset rdata
        do_acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sw_rdata got=%h exp=%h", rd, e); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL sw_latency got=%0d exp=1", lat); end
        n_tests++; if (bc !== 1) begin n_fail++; $display("FAIL sw_busy_cycles got=%0d exp=1", bc); end
        exp_q.push_back(32'hDEADBEEF);
        do_acc(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL lw_rdata got=%h exp=%h", rd, e); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL lw_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_subword;
        logic [31:0] rd, e; logic err; int lat, bc;
        logic [1:0]  sz   [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        bit          sx   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad   [4] = '{32'h20, 32'h23, 32'h22, 32'h20};
        logic [31:0] ex   [4] = '{32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            do_acc(1'b0, 1'b0, sz[i], sx[i], ad[i], 32'h0, rd, err, lat, bc);
            e = exp_q.pop_front();
            n_tests++; if (rd !== e) begin n_fail++; $display("FAIL subword_load[%0d] got=%h exp=%h", i, rd, e); end
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd, e; logic err; int lat, bc;
        exp_q.push_back(32'h0000BEEF);          // sb must not disturb rdata
        do_acc(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h00000055, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sb_rdata_held got=%h exp=%h", rd, e); end
        exp_q.push_back(32'hDEAD55EF);
        do_acc(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sb_merge got=%h exp=%h", rd, e); end
    endtask

    task automatic test_wait_states;
        logic [31:0] rd, e; logic err; int lat, bc, pulses;
        exp_q.push_back(32'h0);
        do_acc(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_latency got=%0d exp=4", lat); end
        n_tests++; if (bc !== 4) begin n_fail++; $display("FAIL ws3_busy_cycles got=%0d exp=4", bc); end
        // lw @0x44 with a conflicting store presented while busy
        exp_q.push_back(32'h0);
        pulses = 0;
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'hFFFFFFFF);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) drv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
            if (bus3.ready) begin
                pulses++;
                e = exp_q.pop_front();
                n_tests++; if (bus3.rdata !== e) begin n_fail++; $display("FAIL ws3_load got=%h exp=%h", bus3.rdata, e); end
            end
            @(negedge clk);
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ws3_ready_pulses got=%0d exp=1", pulses); end
        exp_q.push_back(32'h0);
        do_acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL ws3_ignored_store got=%h exp=%h", rd, e); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        exp_q.push_back(32'h13579BDF);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h13579BDF);
        @(posedge clk);
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready got=%b exp=1", bus0.ready); end
        @(posedge clk);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        n_tests++; if (bus0.busy !== 1'b1 || bus0.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept busy/ready got=%b/%b exp=1/0", bus0.busy, bus0.ready); end
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus0.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready got=%b exp=1", bus0.ready); end
        e = exp_q.pop_front();
        n_tests++; if (bus0.rdata !== e) begin n_fail++; $display("FAIL b2b_raw got=%h exp=%h", bus0.rdata, e); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd, e; logic err; int lat, bc, seen;
        exp_q.push_back(32'h0);
        do_acc(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, rd, err, lat, bc);
        e = exp_q.pop_front();
        seen = 0;
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111);
        @(posedge clk);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus3.ready) seen++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus3.ready) seen++;
            @(negedge clk);
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_ready got=%0d pulses exp=0", seen); end
        n_tests++; if (bus3.rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rdata_reset got=%h exp=0", bus3.rdata); end
        exp_q.push_back(32'hCAFEF00D);
        do_acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL abort_no_write got=%h exp=%h", rd, e); end
    endtask

    task automatic test_alias_misalign;
        logic [31:0] rd, e; logic err; int lat, bc;
        do_acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hA5A5A5A5, rd, err, lat, bc);
        exp_q.push_back(32'hA5A5A5A5);
        do_acc(1'b0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL alias_wrap got=%h exp=%h", rd, e); end
        exp_q.push_back(32'hA5A5A5A5);          // sh never updates rdata
        do_acc(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sh_rdata_held got=%h exp=%h", rd, e); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL sh_latency got=%0d exp=1", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL sh_addr_err got=%b exp=1", err); end
        exp_q.push_back(32'hDEAD55EF);
        do_acc(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sh_suppressed got=%h exp=%h", rd, e); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL lw_addr_err got=%b exp=0", err); end
`else
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL sh_addr_err got=%b exp=0", err); end
        exp_q.push_back(32'h00001234);
        do_acc(1'b0, 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sh_aligned got=%h exp=%h", rd, e); end
        exp_q.push_back(32'hDEAD1234);
        do_acc(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, err, lat, bc);
        e = exp_q.pop_front();
        n_tests++; if (rd !== e) begin n_fail++; $display("FAIL sh_upper_intact got=%h exp=%h", rd, e); end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_word();
        test_subword();
        test_byte_store();
        test_wait_states();
        test_back_to_back();
        test_reset_abort();
        test_alias_misalign();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
